// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer and graphics datapath.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StPlay = 2'b01,
      StStep = 2'b10,
      StOver = 2'b11
   } game_state_e;

   // Opposite directions differ only in the upper bit of the encoding.
   function automatic dir_e opposite(input dir_e d);
      return dir_e'(d ^ 2'b10);
   endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// Button decode, no-reversal filter, pending direction and committed direction.
module snake_dir_latch
   import snake_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic up,
   input  logic down,
   input  logic left,
   input  logic right,
   input  logic track,    // accept filtered requests into pending
   input  logic start,    // load pending and dir unfiltered (game start)
   input  logic commit,   // copy pending into the committed dir
   output logic any_btn,
   output dir_e dir
);

   dir_e req_dir;
   dir_e pending;
   dir_e pending_next;

   // Priority decode: up > down > left > right.
   always_comb begin
      any_btn = up | down | left | right;
      req_dir = DIR_RIGHT;
      if (up)         req_dir = DIR_UP;
      else if (down)  req_dir = DIR_DOWN;
      else if (left)  req_dir = DIR_LEFT;
      else if (right) req_dir = DIR_RIGHT;
   end

   // Reversal is judged against the committed dir, so the last legal request wins.
   always_comb begin
      pending_next = pending;
      if (track && any_btn && (req_dir != opposite(dir))) pending_next = req_dir;
   end

   // Pending and committed direction registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= DIR_RIGHT;
         dir     <= DIR_RIGHT;
      end else if (start) begin
         pending <= req_dir;
         dir     <= req_dir;
      end else begin
         pending <= pending_next;
         if (commit) dir <= pending_next;
      end
   end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: frame pacing, move handshake, score and speed-up.
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 8,
   parameter int unsigned MIN_FRAMES      = 2,
   parameter int unsigned SCORE_W         = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               up,
   input  logic               down,
   input  logic               left,
   input  logic               right,
   input  logic               frame_tick,
   input  logic               step_ack,
   input  logic               collision,
   input  logic               food_eaten,
   output logic               step_req,
   output logic [1:0]         dir,
   output logic               grow,
   output logic [1:0]         game_state,
   output logic [SCORE_W-1:0] score
);

   localparam int unsigned PW = $clog2(FRAMES_PER_STEP + 1);
   localparam logic [PW-1:0] PERIOD_INIT = PW'(FRAMES_PER_STEP);
   localparam logic [PW-1:0] PERIOD_MIN  = PW'(MIN_FRAMES);

   game_state_e        state;
   logic [PW-1:0]      period;
   logic [PW-1:0]      frame_cnt;
   logic [SCORE_W-1:0] score_r;
   logic               any_btn;
   logic               step_due;
   dir_e               dir_cur;

   // Last frame of the current period while playing.
   always_comb begin
      step_due = (state == StPlay) && frame_tick && (frame_cnt == period - PW'(1));
   end

   snake_dir_latch u_dir_latch (
      .clk     (clk),
      .rst_n   (rst_n),
      .up      (up),
      .down    (down),
      .left    (left),
      .right   (right),
      .track   ((state == StPlay) || (state == StStep)),
      .start   ((state == StIdle) && any_btn),
      .commit  (step_due),
      .any_btn (any_btn),
      .dir     (dir_cur)
   );

   // Game FSM with frame counter, speed and score; all outputs registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         step_req  <= 1'b0;
         grow      <= 1'b0;
         score_r   <= '0;
         period    <= PERIOD_INIT;
         frame_cnt <= '0;
      end else begin
         grow <= 1'b0;
         unique case (state)
            StIdle: begin
               score_r   <= '0;
               period    <= PERIOD_INIT;
               frame_cnt <= '0;
               step_req  <= 1'b0;
               if (any_btn) state <= StPlay;
            end
            StPlay: begin
               if (step_due) begin
                  frame_cnt <= '0;
                  step_req  <= 1'b1;
                  state     <= StStep;
               end else if (frame_tick) begin
                  frame_cnt <= frame_cnt + PW'(1);
               end
            end
            StStep: begin
               if (step_ack) begin
                  step_req <= 1'b0;
                  if (collision) begin
                     state <= StOver;
                  end else begin
                     state <= StPlay;
                     if (food_eaten) begin
                        grow    <= 1'b1;
                        score_r <= (&score_r) ? score_r : score_r + SCORE_W'(1);
                        period  <= (period > PERIOD_MIN) ? period - PW'(1) : PERIOD_MIN;
                     end
                  end
               end
            end
            StOver: begin
               step_req <= 1'b0;
               // Clear on the way out so IDLE never shows a stale score.
               if (!any_btn) begin
                  state     <= StIdle;
                  score_r   <= '0;
                  period    <= PERIOD_INIT;
                  frame_cnt <= '0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign dir        = dir_cur;
   assign game_state = state;
   assign score      = score_r;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: directed stimulus, decoupled monitor.
module tb_snake_game_ctrl;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_PLAY = 2'b01;
   localparam logic [1:0] S_STEP = 2'b10;
   localparam logic [1:0] S_OVER = 2'b11;

   localparam logic [1:0] D_UP    = 2'b00;
   localparam logic [1:0] D_RIGHT = 2'b01;
   localparam logic [1:0] D_DOWN  = 2'b10;

   // Button vectors {up, down, left, right}.
   localparam logic [3:0] B_UP    = 4'b1000;
   localparam logic [3:0] B_DOWN  = 4'b0100;
   localparam logic [3:0] B_LEFT  = 4'b0010;
   localparam logic [3:0] B_RIGHT = 4'b0001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       up, down, left, right;
   logic       frame_tick, step_ack, collision, food_eaten;
   logic       step_req, grow;
   logic [1:0] dir, game_state;
   logic [7:0] score;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0] dir;
      int         ticks;
   } req_t;

   typedef struct {
      logic [1:0] state;
      logic [7:0] score;
      logic       grow;
   } ack_t;

   req_t req_q[$];
   ack_t ack_q[$];

   snake_game_ctrl #(
      .FRAMES_PER_STEP (8),
      .MIN_FRAMES      (2),
      .SCORE_W         (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .frame_tick (frame_tick),
      .step_ack   (step_ack),
      .collision  (collision),
      .food_eaten (food_eaten),
      .step_req   (step_req),
      .dir        (dir),
      .grow       (grow),
      .game_state (game_state),
      .score      (score)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] b);
      @(posedge clk); #1 {up, down, left, right} = b;
      @(posedge clk); #1 {up, down, left, right} = 4'b0000;
   endtask

   // n frame ticks in PLAY; the step_req rise must follow the n-th tick with dir exp_dir.
   task automatic run_period(input int n, input logic [1:0] exp_dir);
      req_t r;
      r.dir   = exp_dir;
      r.ticks = n;
      req_q.push_back(r);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 frame_tick = 1'b1;
         @(posedge clk); #1 frame_tick = 1'b0;
         repeat (2) @(posedge clk);
      end
   endtask

   task automatic wait_req();
      for (int i = 0; i < 64; i++) begin
         if (step_req) break;
         @(negedge clk);
      end
      if (!step_req) begin
         n_vec++;
         n_err++;
         $display("FAIL step_req_timeout: got 0, required 1");
      end
   endtask

   // Acknowledge after a delay; a frame_tick inside STEP must not be counted.
   task automatic do_ack(input int d, input logic col, input logic food,
                         input logic [1:0] exp_state, input logic [7:0] exp_score,
                         input logic exp_grow);
      ack_t a;
      wait_req();
      if (!step_req) return;
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      repeat (d) @(posedge clk);
      #1;
      step_ack   = 1'b1;
      collision  = col;
      food_eaten = food;
      a.state = exp_state;
      a.score = exp_score;
      a.grow  = exp_grow;
      ack_q.push_back(a);
      @(posedge clk); #1;
      step_ack   = 1'b0;
      collision  = 1'b0;
      food_eaten = 1'b0;
   endtask

   // Monitor: checks each step_req rise and each handshake completion against the queues.
   initial begin
      logic prev_req, prev_tick, prev_ack, prev_grow;
      int   ticks;
      req_t r;
      ack_t a;
      prev_req  = 1'b0;
      prev_tick = 1'b0;
      prev_ack  = 1'b0;
      prev_grow = 1'b0;
      ticks     = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_req  = 1'b0;
            prev_tick = 1'b0;
            prev_ack  = 1'b0;
            prev_grow = 1'b0;
            ticks     = 0;
         end else begin
            if (step_req && !prev_req) begin
               if (req_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_step_req: got rise, required none");
               end else begin
                  r = req_q.pop_front();
                  chk("step_dir", 32'(dir), 32'(r.dir));
                  chk("step_ticks", ticks, r.ticks);
                  chk("step_after_tick", 32'(prev_tick), 1);
               end
               ticks = 0;
            end
            if (!step_req && prev_req) begin
               if (ack_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_step_done: got fall, required none");
               end else begin
                  a = ack_q.pop_front();
                  chk("ack_state", 32'(game_state), 32'(a.state));
                  chk("ack_score", 32'(score), 32'(a.score));
                  chk("ack_grow", 32'(grow), 32'(a.grow));
                  chk("ack_latency", 32'(prev_ack), 1);
               end
            end
            if (prev_grow) chk("grow_width", 32'(grow), 0);
            if (game_state == S_PLAY && frame_tick) ticks++;
            if (game_state == S_IDLE || game_state == S_OVER) ticks = 0;
            prev_req  = step_req;
            prev_tick = frame_tick;
            prev_ack  = step_ack;
            prev_grow = grow;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      {up, down, left, right} = 4'b0000;
      frame_tick = 1'b0;
      step_ack   = 1'b0;
      collision  = 1'b0;
      food_eaten = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_state", 32'(game_state), 32'(S_IDLE));
      chk("reset_dir", 32'(dir), 32'(D_RIGHT));
      chk("reset_score", 32'(score), 0);
      chk("reset_step_req", 32'(step_req), 0);
      chk("reset_grow", 32'(grow), 0);

      // Start with up: no reversal check against the reset dir.
      press(B_UP);
      @(negedge clk);
      chk("start_state", 32'(game_state), 32'(S_PLAY));
      chk("start_dir", 32'(dir), 32'(D_UP));

      // Pacing with no buttons.
      run_period(8, D_UP);
      do_ack(3, 1'b0, 1'b0, S_PLAY, 8'd0, 1'b0);

      // step_ack outside STEP is ignored.
      @(posedge clk); #1 step_ack = 1'b1; food_eaten = 1'b1;
      @(posedge clk); #1 step_ack = 1'b0; food_eaten = 1'b0;
      @(negedge clk);
      chk("stray_ack_score", 32'(score), 0);
      chk("stray_ack_state", 32'(game_state), 32'(S_PLAY));
      chk("stray_ack_grow", 32'(grow), 0);

      press(B_RIGHT);
      run_period(8, D_RIGHT);
      do_ack(2, 1'b0, 1'b0, S_PLAY, 8'd0, 1'b0);

      // left is a reversal of right and is dropped; up then wins.
      press(B_LEFT);
      press(B_UP);
      run_period(8, D_UP);
      do_ack(2, 1'b0, 1'b0, S_PLAY, 8'd0, 1'b0);

      press(B_RIGHT);
      run_period(8, D_RIGHT);
      do_ack(2, 1'b0, 1'b0, S_PLAY, 8'd0, 1'b0);

      // Only a reversal: dir stays right. down during STEP goes to pending only.
      press(B_LEFT);
      run_period(8, D_RIGHT);
      wait_req();
      press(B_DOWN);
      @(negedge clk);
      chk("step_dir_hold", 32'(dir), 32'(D_RIGHT));
      chk("step_state_hold", 32'(game_state), 32'(S_STEP));
      do_ack(2, 1'b0, 1'b0, S_PLAY, 8'd0, 1'b0);

      // Food seven times: periods 8,7,6,5,4,3,2 before each ack, then saturated at 2.
      for (int k = 1; k <= 7; k++) begin
         run_period((9 - k > 2) ? 9 - k : 2, D_DOWN);
         do_ack(2, 1'b0, 1'b1, S_PLAY, 8'(k), 1'b1);
      end

      // Collision wins over food; right held through OVER blocks restart.
      run_period(2, D_DOWN);
      wait_req();
      @(posedge clk); #1 right = 1'b1;
      do_ack(2, 1'b1, 1'b1, S_OVER, 8'd7, 1'b0);
      repeat (3) @(negedge clk);
      chk("over_hold_state", 32'(game_state), 32'(S_OVER));
      chk("over_hold_score", 32'(score), 7);
      @(posedge clk); #1 right = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("idle_state", 32'(game_state), 32'(S_IDLE));
      chk("idle_score", 32'(score), 0);

      // Restart, then reset in the middle of the handshake.
      press(B_RIGHT);
      @(negedge clk);
      chk("restart_state", 32'(game_state), 32'(S_PLAY));
      chk("restart_dir", 32'(dir), 32'(D_RIGHT));
      run_period(8, D_RIGHT);
      wait_req();
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("rst_step_req", 32'(step_req), 0);
      chk("rst_state", 32'(game_state), 32'(S_IDLE));
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_state", 32'(game_state), 32'(S_IDLE));
      chk("post_rst_dir", 32'(dir), 32'(D_RIGHT));
      chk("post_rst_score", 32'(score), 0);
      chk("post_rst_step_req", 32'(step_req), 0);

      repeat (4) @(negedge clk);
      chk("req_queue_drained", req_q.size(), 0);
      chk("ack_queue_drained", ack_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game sequencer for the snake display path. It sits between the push-button inputs and the graphics datapath. It runs the IDLE/PLAY/STEP/OVER state machine and paces snake moves by counting VGA frames. It latches direction with a no-reversal rule, and issues one move request per step to the graphics unit over a req/ack handshake. It also tracks score and speeds the game up as food is eaten.

## Interface
- FRAMES_PER_STEP, 8, initial number of frames between moves (≥2)
- MIN_FRAMES, 2, fastest allowed period (1 ≤ MIN_FRAMES ≤ FRAMES_PER_STEP)
- SCORE_W, 8, score counter width

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- up, down, left, right  in  1 each  button levels, already synchronized to clk
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blanking)
- step_ack  in  1  graphics datapath finished applying the requested move
- collision  in  1  valid only in the step_ack cycle; head hit wall/body
- food_eaten  in  1  valid only in the step_ack cycle; head landed on food
- step_req  out  1  move request, held until acknowledged
- dir  out  2  committed direction: 00 up, 01 right, 10 down, 11 left
- grow  out  1  one-cycle pulse: extend body by one segment
- game_state  out  2  00 IDLE, 01 PLAY, 10 STEP, 11 OVER
- score  out  SCORE_W  food count, saturating

## Operation
**Reset values:** IDLE, step_req=0, dir=01, grow=0, score=0, period=FRAMES_PER_STEP, frame counter=0, pending dir=01.

**Button decode:** priority up > down > left > right. If no button is pressed, there is no request.

**Pending direction:** updated in PLAY and STEP from a decoded request. A request opposite to the committed dir is ignored (e.g. dir=01 ignores left). In the same cycle that step_req rises, the committed dir takes the value of pending.

**IDLE:** score=0, period=FRAMES_PER_STEP, counter=0. Any button → PLAY. Pending and dir are loaded with the decoded button, with no reversal check.

**PLAY:** on each frame_tick, counter increments. When frame_tick arrives with counter==period-1: counter←0, step_req←1, → STEP.

**STEP:** step_req stays high and dir stays stable until step_ack. frame_tick is not counted. On step_ack:
- collision=1 → OVER; score unchanged; no grow.
- else food_eaten=1 → score+1, saturating at all-ones; period←max(period-1, MIN_FRAMES); grow pulse; → PLAY.
- else → PLAY.

**OVER:** step_req=0. Score is held. When all four buttons are low → IDLE. A button still held from gameplay therefore cannot restart the game immediately.

step_ack outside STEP is ignored.

## Timing
- All outputs are registered.
- frame_tick that ends the period at cycle T → step_req=1 and new dir at T+1.
- step_ack at cycle A → step_req=0 and game_state updated at A+1. grow=1 only at A+1. score updates at A+1.
- step_ack in the same cycle as step_req rising is impossible; the datapath is required to wait at least one cycle.
- Button changes in STEP affect pending only. dir changes only at the next step_req rise.
- Multiple direction changes within one period: the last non-reversing request wins. A reversal is evaluated against the committed dir, not against pending.
- Reset assertion in any state: all registers return to reset values immediately (asynchronous), and step_req drops without waiting for ack.
- Minimum move period = MIN_FRAMES frames plus the handshake latency.

## Structure
- Shared package snake_pkg holds:
  - direction encodings (DIR_UP/RIGHT/DOWN/LEFT)
  - game_state encodings
  - an opposite(dir) function, also used by the graphics datapath
- Sub-module snake_dir_latch: button priority decode, reversal filter, pending register, and commit on a load strobe. Everything else is a single FSM plus counters in snake_game_ctrl.

## Test plan
- **Reset/start:** release reset with no buttons → IDLE, dir=01, score=0. Press up for 1 cycle → PLAY, dir=00.
- **Pacing:** FRAMES_PER_STEP=8, no food; 8 frame_ticks → step_req rises the cycle after the 8th tick. Ack 3 cycles later → step_req low the next cycle, back in PLAY.
- **Reversal:** dir=01; press left, then up, in one period → next step has dir=00. Pressing only left → dir stays 01.
- **Speed-up/saturation:** ack with food_eaten 7 times from period 8, MIN_FRAMES=2 → period sequence 7,6,5,4,3,2,2; score=7; each ack is followed by a one-cycle grow.
- **Game over/restart:** ack with collision=1 and food_eaten=1 → OVER, score unchanged, no grow. Holding right keeps OVER; releasing → IDLE, score cleared on entry.
- **Reset mid-handshake:** assert reset while step_req=1 → step_req=0 immediately; state IDLE after reset release.
